// File: rtl/ddr_burst_writer.sv
// Streams fixed-length AXI4 INCR write bursts from an AXI-Stream source to memory.
// Limits outstanding bursts and reports job completion and sticky write errors.
module ddr_burst_writer #(
    parameter int unsigned ADDR_W    = 40,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                ps_clk,
    input  logic                ps_rstb,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [15:0]         num_bursts,
    output logic                busy,
    output logic                done,
    output logic                error,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [ID_W-1:0]     m_awid,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic [3:0]          m_awcache,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [ID_W-1:0]     m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    localparam int unsigned       BYTES       = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BYTES);
    localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [15:0]       OUTST       = 16'(MAX_OUTST);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_aw_addr;
    logic [15:0]       r_num;
    logic [15:0]       r_aw_cnt;
    logic [15:0]       r_w_burst_cnt;
    logic [15:0]       r_b_cnt;
    logic [7:0]        r_beat;
    logic              r_error;

    logic              w_run;
    logic              w_start_acc;
    logic              w_w_allow;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic [15:0]       w_b_cnt_nxt;
    logic              w_unused;

    assign w_run       = (r_state == StRun);
    assign w_start_acc = (r_state == StIdle) && start;
    // W beats may only run behind bursts whose address has been accepted.
    assign w_w_allow   = w_run && (r_w_burst_cnt < r_aw_cnt);
    assign w_aw_hs     = m_awvalid && m_awready;
    assign w_w_hs      = m_wvalid && m_wready;
    assign w_b_hs      = m_bvalid && m_bready;
    assign w_b_cnt_nxt = r_b_cnt + 16'd1;
    assign w_unused    = ^m_bid;

    always_ff @(posedge ps_clk or negedge ps_rstb) begin
        if (!ps_rstb) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = (num_bursts == 16'd0) ? StFinish : StRun;
                end
            end
            StRun: begin
                if (w_b_hs && (w_b_cnt_nxt == r_num)) begin
                    w_state_nxt = StFinish;
                end
            end
            StFinish: w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge ps_clk or negedge ps_rstb) begin
        if (!ps_rstb) begin
            r_aw_addr     <= '0;
            r_num         <= '0;
            r_aw_cnt      <= '0;
            r_w_burst_cnt <= '0;
            r_b_cnt       <= '0;
            r_beat        <= '0;
            r_error       <= 1'b0;
        end else if (w_start_acc) begin
            r_aw_addr     <= base_addr;
            r_num         <= num_bursts;
            r_aw_cnt      <= '0;
            r_w_burst_cnt <= '0;
            r_b_cnt       <= '0;
            r_beat        <= '0;
            r_error       <= 1'b0;
        end else if (w_run) begin
            if (w_aw_hs) begin
                r_aw_cnt  <= r_aw_cnt + 16'd1;
                r_aw_addr <= r_aw_addr + BURST_BYTES;
            end
            if (w_w_hs) begin
                if (m_wlast) begin
                    r_beat        <= '0;
                    r_w_burst_cnt <= r_w_burst_cnt + 16'd1;
                end else begin
                    r_beat <= r_beat + 8'd1;
                end
            end
            if (w_b_hs) begin
                r_b_cnt <= w_b_cnt_nxt;
                if (m_bresp != 2'b00) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign busy      = w_run;
    assign done      = (r_state == StFinish);
    assign error     = r_error;

    // AW valid can only fall through its own handshake, so the address stays stable while stalled.
    assign m_awvalid = w_run && (r_aw_cnt < r_num) && ((r_aw_cnt - r_b_cnt) < OUTST);
    assign m_awaddr  = r_aw_addr;
    assign m_awlen   = LAST_BEAT;
    assign m_awid    = '0;
    assign m_awsize  = 3'($clog2(BYTES));
    assign m_awburst = 2'b01;
    assign m_awcache = 4'b0011;

    assign m_wvalid  = w_w_allow && s_tvalid;
    assign s_tready  = w_w_allow && m_wready;
    assign m_wdata   = s_tdata;
    assign m_wstrb   = '1;
    assign m_wlast   = (r_beat == LAST_BEAT);

    assign m_bready  = w_run;

endmodule

// File: tb/tb_ddr_burst_writer.sv
// Randomized self-checking bench for ddr_burst_writer: a job-level model predicts every
// handshake-visible output each cycle while a simple memory model answers AW/W/B.
module tb_ddr_burst_writer;

    localparam int BL = 16;

    logic          ps_clk = 1'b0;
    logic          ps_rstb;
    logic          start;
    logic [39:0]   base_addr;
    logic [15:0]   num_bursts;
    logic          busy, done, error;
    logic [255:0]  s_tdata;
    logic          s_tvalid, s_tready;
    logic [39:0]   m_awaddr;
    logic [7:0]    m_awlen;
    logic [3:0]    m_awid;
    logic          m_awvalid, m_awready;
    logic [2:0]    m_awsize;
    logic [1:0]    m_awburst;
    logic [3:0]    m_awcache;
    logic [255:0]  m_wdata;
    logic [31:0]   m_wstrb;
    logic          m_wlast, m_wvalid, m_wready;
    logic [3:0]    m_bid;
    logic [1:0]    m_bresp;
    logic          m_bvalid, m_bready;

    ddr_burst_writer dut (
        .ps_clk(ps_clk), .ps_rstb(ps_rstb), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .busy(busy), .done(done), .error(error),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awid(m_awid), .m_awvalid(m_awvalid),
        .m_awready(m_awready), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awcache(m_awcache), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 ps_clk = ~ps_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus knobs shared with the memory/stream driver.
    bit          rdy_all, tv_all, b_hold;
    int          aw_stall;
    logic [15:0] err_mask;
    int          b_pend[$];

    // Job model state.
    logic [39:0] md_base;
    int          md_num, md_aw, md_b, md_beat, md_wbursts, md_wbeats;
    bit          md_run, md_fin, md_err;
    bit          hs_w, hs_b;

    always @(negedge ps_clk) begin : mon
        bit          acc, allow, aw_hs, w_hs, b_hs;
        logic [39:0] exp_addr;
        if (!ps_rstb) begin
            md_run = 0; md_fin = 0; md_err = 0; md_base = '0; md_num = 0;
            md_aw = 0; md_b = 0; md_beat = 0; md_wbursts = 0; md_wbeats = 0;
            hs_w = 0; hs_b = 0;
        end else begin
            acc = start && !md_run && !md_fin;
            check("busy", busy, md_run);
            check("done", done, md_fin);
            check("error", error, md_err);
            check("bready", m_bready, md_run);
            allow = md_run && (md_wbursts < md_aw);
            check("wvalid", m_wvalid, allow && s_tvalid);
            check("tready", s_tready, allow && m_wready);
            check("awvalid", m_awvalid, md_run && (md_aw < md_num) && ((md_aw - md_b) < 4));
            if (m_awvalid) begin
                exp_addr = md_base + (40'(md_aw) << 9);
                check("awaddr", m_awaddr, exp_addr);
                check("awlen", m_awlen, BL - 1);
                check("awid", m_awid, 0);
            end
            aw_hs = m_awvalid && m_awready;
            w_hs  = m_wvalid && m_wready;
            b_hs  = m_bvalid && m_bready;
            if (w_hs) begin
                check("wlast", m_wlast, md_beat == BL - 1);
                check("wdata", m_wdata == s_tdata, 1);
            end
            md_fin = 0;
            if (acc) begin
                md_base = base_addr; md_num = int'(num_bursts);
                md_aw = 0; md_b = 0; md_beat = 0; md_wbursts = 0; md_wbeats = 0; md_err = 0;
                if (num_bursts == 0) md_fin = 1; else md_run = 1;
            end else if (md_run) begin
                if (aw_hs) md_aw++;
                if (w_hs) begin
                    md_wbeats++;
                    if (md_beat == BL - 1) begin
                        md_beat = 0;
                        b_pend.push_back(md_wbursts);
                        md_wbursts++;
                    end else begin
                        md_beat++;
                    end
                end
                if (b_hs) begin
                    md_b++;
                    if (m_bresp != 2'b00) md_err = 1;
                    if (md_b == md_num) begin
                        md_run = 0;
                        md_fin = 1;
                    end
                end
            end
            hs_w = w_hs;
            hs_b = b_hs;
        end
    end

    // Memory and stream source, driven just after each rising edge.
    initial begin : drv
        m_awready = 0; m_wready = 0; s_tvalid = 0; s_tdata = '0;
        m_bvalid = 0; m_bresp = 2'b00; m_bid = '0;
        forever begin
            @(posedge ps_clk);
            #1;
            if (!ps_rstb) begin
                m_awready = 0; m_wready = 0; s_tvalid = 0; m_bvalid = 0;
                b_pend.delete();
            end else begin
                if (aw_stall > 0) begin
                    m_awready = 0;
                    if (m_awvalid) aw_stall--;
                end else begin
                    m_awready = rdy_all || ($urandom_range(0, 3) != 0);
                end
                m_wready = rdy_all || ($urandom_range(0, 3) != 0);
                if (hs_w || !s_tvalid) begin
                    for (int k = 0; k < 8; k++) s_tdata[k*32 +: 32] = $urandom;
                    s_tvalid = rdy_all || tv_all || ($urandom_range(0, 3) != 0);
                end
                if (hs_b) begin
                    m_bvalid = 0;
                    if (b_pend.size() > 0) void'(b_pend.pop_front());
                end
                if (!m_bvalid && b_pend.size() > 0 && !b_hold &&
                    (rdy_all || $urandom_range(0, 2) == 0)) begin
                    m_bvalid = 1;
                    m_bresp  = err_mask[b_pend[0]] ? 2'b10 : 2'b00;
                end
            end
        end
    end

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge ps_clk);
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
    endtask

    task automatic run_job(input logic [39:0] base, input int num, input logic [15:0] mask,
                           input bit all_rdy, input bit tv, input int stall, input bit hold,
                           input bit poke);
        bit exp_err = 0;
        rdy_all = all_rdy; tv_all = tv; err_mask = mask; aw_stall = stall; b_hold = hold;
        @(posedge ps_clk); #1;
        start = 1; base_addr = base; num_bursts = 16'(num);
        @(posedge ps_clk); #1;
        start = 0; base_addr = {$urandom, $urandom}; num_bursts = 16'($urandom);
        check("busy_after_start", busy, num != 0);
        check("error_cleared", error, 0);
        if (poke) begin
            repeat (2) @(posedge ps_clk);
            #1 start = 1;
            @(posedge ps_clk);
            #1 start = 0;
        end
        if (hold) begin
            for (int i = 0; i < 2000 && md_wbursts < 4; i++) @(negedge ps_clk);
            repeat (10) @(negedge ps_clk);
            check("hold_aw_total", md_aw, 4);
            check("hold_awvalid", m_awvalid, 0);
            b_hold = 0;
        end
        wait_done();
        for (int i = 0; i < num; i++) exp_err |= mask[i];
        check("err_at_done", error, exp_err);
        check("aw_total", md_aw, num);
        check("w_beats", md_wbeats, num * BL);
        @(negedge ps_clk);
        check("done_width", done, 0);
    endtask

    initial begin : main
        ps_rstb = 0; start = 0; base_addr = '0; num_bursts = '0;
        rdy_all = 0; tv_all = 0; b_hold = 0; aw_stall = 0; err_mask = '0;
        repeat (3) @(posedge ps_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_bready", m_bready, 0);
        check("rst_tready", s_tready, 0);
        check("awsize", m_awsize, 5);
        check("awburst", m_awburst, 1);
        check("awcache", m_awcache, 3);
        check("wstrb", m_wstrb, 32'hFFFF_FFFF);
        @(posedge ps_clk);
        #1 ps_rstb = 1;

        run_job(40'h1000, 2, 16'h0, 1, 1, 0, 0, 0);
        run_job(40'h4_0000, 8, 16'h0, 0, 0, 0, 1, 0);
        run_job(40'h8000, 2, 16'h0, 0, 1, 5, 0, 0);
        run_job(40'h2_0000, 3, 16'h0002, 0, 0, 0, 0, 1);
        run_job(40'h3_0000, 1, 16'h0, 0, 0, 0, 0, 0);
        run_job(40'h5000, 0, 16'h0, 0, 0, 0, 0, 0);
        run_job(40'hFF_FFFF_FC00, 4, 16'h0, 0, 0, 0, 0, 1);
        for (int j = 0; j < 6; j++) begin
            logic [39:0] b;
            b = {$urandom, $urandom};
            b[8:0] = '0;
            run_job(b, $urandom_range(1, 6), 16'($urandom) & 16'h003F,
                    bit'($urandom_range(0, 1)), 0, 0, 0, 1);
        end

        rdy_all = 0; tv_all = 0; err_mask = '0; aw_stall = 0; b_hold = 0;
        @(posedge ps_clk); #1;
        start = 1; base_addr = 40'h20_0000_0000; num_bursts = 16'd6;
        @(posedge ps_clk); #1;
        start = 0;
        for (int i = 0; i < 2000 && md_wbeats < 5; i++) @(negedge ps_clk);
        @(posedge ps_clk);
        #1 ps_rstb = 0;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_awvalid", m_awvalid, 0);
        check("mid_rst_wvalid", m_wvalid, 0);
        check("mid_rst_bready", m_bready, 0);
        check("mid_rst_tready", s_tready, 0);
        check("mid_rst_awaddr", m_awaddr, 0);
        repeat (3) @(posedge ps_clk);
        #1 ps_rstb = 1;
        repeat (20) @(posedge ps_clk);
        run_job(40'h30_0000_0400, 3, 16'h0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

endmodule
